// File: rtl/smac_pkg.sv
// smac shared definitions: widths, iteration count,
// controller state encoding and Booth-pair codes.
package smac_pkg;

   localparam int OP_W  = 4;
   localparam int RES_W = 8;
   localparam int ITER  = 4;
   localparam int CNT_W = 2;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   // {b[i], b[i-1]}
   localparam logic [1:0] BOOTH_SUB = 2'b10;
   localparam logic [1:0] BOOTH_ADD = 2'b01;

endpackage

// File: rtl/smac_controller.sv
// smac controller: IDLE/BUSY state and iteration count.
// Ports: clk, reset, start in; load, step, ready, count out.
module smac_controller
   import smac_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             load,
   output logic             step,
   output logic             ready,
   output logic [CNT_W-1:0] count
);

   logic [0:0] state;

   assign load  = (state == S_IDLE) && start;
   assign step  = (state == S_BUSY);
   assign ready = (state == S_IDLE) && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         count <= '0;
      end else if (load) begin
         state <= S_BUSY;
         count <= CNT_W'(ITER - 1);
      end else if (step) begin
         if (count == '0)
            state <= S_IDLE;
         else
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/smac.sv
// smac: sequential signed a*b+c, radix-2 Booth, 4 steps.
// Ports: clk, reset, start, a, b, c, chk in;
//        product, match, ready out.
module smac
   import smac_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   input  logic [OP_W-1:0]  c,
   input  logic [RES_W-1:0] chk,
   output logic [RES_W-1:0] product,
   output logic             match,
   output logic             ready
);

   logic             load;
   logic             step;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] idx;
   logic [OP_W-1:0]  a_reg;
   logic [OP_W-1:0]  b_reg;
   logic [RES_W-1:0] chk_reg;
   logic [RES_W-1:0] acc;
   logic [RES_W-1:0] acc_nxt;
   logic [RES_W-1:0] a_sh;
   logic [OP_W:0]    b_ext;
   logic [1:0]       pair;

   smac_controller u_ctrl (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .load  (load),
      .step  (step),
      .ready (ready),
      .count (count)
   );

   // count runs 3..0, so the bit index runs 0..3
   assign idx   = CNT_W'(ITER - 1) - count;
   // appended zero is the implicit bit -1
   assign b_ext = {b_reg, 1'b0};
   assign pair  = b_ext[idx +: 2];
   assign a_sh  = {{(RES_W-OP_W){a_reg[OP_W-1]}},
                   a_reg} << idx;

   always_comb begin
      acc_nxt = acc;
      unique case (pair)
         BOOTH_ADD: acc_nxt = acc + a_sh;
         BOOTH_SUB: acc_nxt = acc - a_sh;
         default:   acc_nxt = acc;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_reg   <= '0;
         b_reg   <= '0;
         chk_reg <= '0;
         acc     <= '0;
      end else if (load) begin
         a_reg   <= a;
         b_reg   <= b;
         chk_reg <= chk;
         acc     <= {{(RES_W-OP_W){c[OP_W-1]}}, c};
      end else if (step) begin
         acc     <= acc_nxt;
      end
   end

   assign product = acc;
   assign match   = ready && (acc == chk_reg);

endmodule
